bram_port_ctrl: RTL and testbench
=================================

Name: bram_port_ctrl

Overview:
- Request/response master that drives the single-port block RAM cache (the 256 x 32 negedge-clocked BRAM) on behalf of a core.
- Accepts word reads, full-word writes and byte-enabled partial writes over a valid/ready request channel.
- The BRAM has no byte enables, so partial writes are done as a read-modify-write.
- Returns one response per request over a valid/ready response channel, with one request outstanding at a time.

Parameters:
- ADDR_W, 8, word address width; must match the BRAM depth of 2**ADDR_W.
- DATA_W, 32, word width; must be a multiple of 8.
- BE_W, DATA_W/8, number of byte enables (derived; do not override).

Ports:
- clk  in  1  system clock; controller logic is posedge, BRAM is negedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high at a posedge.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  BE_W  byte enables for a write; ignored for a read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DATA_W  read data, or the merged word actually written.
- mem_w_en  out  1  to BRAM w_en.
- mem_r_en  out  1  to BRAM r_en.
- mem_addr  out  ADDR_W  to BRAM addr.
- mem_data_in  out  DATA_W  to BRAM data_in.
- mem_data_o  in  DATA_W  from BRAM data_o.

Behaviour:
- Reset (async, any state): state=IDLE; req_ready=0 while rst is high, then 1 from the first posedge after release. All other outputs 0. Latched request fields are cleared.
- All mem_* outputs are registered on posedge, so they are stable across the BRAM's negedge. mem_w_en and mem_r_en are never both high, and each pulse lasts exactly one cycle.
- mem_data_o is sampled only at the posedge that ends a cycle in which mem_r_en=1.
- FSM states: IDLE, RD, RMW_WR, RESP.
- IDLE: req_ready=1. On accept at edge E0, latch we/be/addr/wdata and branch:
  - Read, or write with be==0: mem_r_en=1 for cycle E0..E1; go to RD. A write with be==0 never asserts mem_w_en.
  - Write with be all ones: mem_w_en=1, mem_data_in=wdata for cycle E0..E1; resp_rdata<=wdata; go to RESP.
  - Partial write (be neither all ones nor zero): mem_r_en=1; go to RD.
- RD, at E1:
  - Plain read: resp_rdata<=mem_data_o; go to RESP.
  - Partial write: compute merged word. Byte i = wdata[8i+7:8i] if be[i], else mem_data_o byte i. Drive mem_w_en=1 and mem_data_in=merged for cycle E1..E2; resp_rdata<=merged; go to RMW_WR.
- RMW_WR, at E2: go to RESP.
- RESP: resp_valid=1; resp_rdata held stable until resp_ready. At the handshake edge, drop resp_valid and go to IDLE. req_ready returns high the cycle after.
- req_ready is high only in IDLE; there is no request pipelining.
- Latency from accept edge to resp_valid visible: read 1 cycle, full write 1 cycle, partial write 2 cycles.
- Backpressure: while resp_ready=0, no BRAM access is issued and req_ready=0.
- Address is used as-is; there is no wrap or bounds logic, and the full ADDR_W range is valid.
- Reset mid-operation: any pending response is discarded. A write in flight either completes entirely at the negedge or does not happen. A partially merged word is never written.

Decomposition:
- Shared package bram_pkg holds the ADDR_W/DATA_W defaults, the state encoding (IDLE=0, RD=1, RMW_WR=2, RESP=3) and a byte_merge function (old, new, be).
- No sub-module; the single FSM with the datapath inline is natural at this size.

Test Plan:
- Reset while resp_valid=1 -> all outputs 0 immediately; req_ready=1 at the first posedge after release; no mem_w_en pulse seen afterwards.
- Full write addr=0x10, data=0xDEADBEEF, be=0xF; then read addr=0x10 -> one mem_w_en pulse; write response rdata=0xDEADBEEF after 1 cycle; read response rdata=0xDEADBEEF after 1 cycle.
- Preload addr=0x20 with 0x11223344, partial write be=0x5, wdata=0xAABBCCDD -> mem_r_en pulse, then mem_w_en pulse with 0x11BB33DD; resp_rdata=0x11BB33DD at 2-cycle latency; readback matches.
- Write be=0x0 to addr=0x20 -> no mem_w_en; resp_rdata=0x11BB33DD.
- Read addr=0xFF with resp_ready held low for 5 cycles -> resp_valid and rdata stable all 5 cycles; req_ready=0; no mem_* pulses; IDLE one cycle after the handshake.
- 200 random back-to-back requests against a scoreboard model -> data match; never mem_w_en and mem_r_en high together; each enable is a single-cycle pulse.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM port controller: default geometry, FSM
// state encoding and the byte-lane merge used by read-modify-write.
package bram_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    // Widest word byte_merge handles; callers zero-extend narrower words.
    localparam int MERGE_W    = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD     = 2'd1,
        RMW_WR = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]   old_word,
        input logic [MERGE_W-1:0]   new_word,
        input logic [MERGE_W/8-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_W/8; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_port_ctrl.sv
// Request/response master for a negedge-clocked single-port BRAM; partial
// writes are performed as read-modify-write since the RAM has no byte enables.
module bram_port_ctrl
    import bram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BE_W   = DATA_W/8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BE_W-1:0]   req_be,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_o
);

    state_t              state;
    logic                lat_we;
    logic [BE_W-1:0]     lat_be;
    logic [DATA_W-1:0]   lat_wdata;

    logic [MERGE_W-1:0]         merge_old;
    logic [MERGE_W-1:0]         merge_new;
    logic [MERGE_W/8-1:0]       merge_be;
    logic [MERGE_W-1:0]         merge_full;
    logic [DATA_W-1:0]          merged;
    logic [MERGE_W-DATA_W-1:0]  merge_hi_unused;

    always_comb begin
        merge_old                = '0;
        merge_new                = '0;
        merge_be                 = '0;
        merge_old[DATA_W-1:0]    = mem_data_o;
        merge_new[DATA_W-1:0]    = lat_wdata;
        merge_be[BE_W-1:0]       = lat_be;
        merge_full               = byte_merge(merge_old, merge_new, merge_be);
        merged                   = merge_full[DATA_W-1:0];
        merge_hi_unused          = merge_full[MERGE_W-1:DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            mem_w_en    <= 1'b0;
            mem_r_en    <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            lat_we      <= 1'b0;
            lat_be      <= '0;
            lat_wdata   <= '0;
        end else begin
            // Enables are single-cycle pulses unless re-armed below.
            mem_w_en <= 1'b0;
            mem_r_en <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        lat_we    <= req_we;
                        lat_be    <= req_be;
                        lat_wdata <= req_wdata;
                        mem_addr  <= req_addr;
                        if (req_we && (req_be == {BE_W{1'b1}})) begin
                            mem_w_en    <= 1'b1;
                            mem_data_in <= req_wdata;
                            resp_rdata  <= req_wdata;
                            state       <= RESP;
                        end else begin
                            mem_r_en <= 1'b1;
                            state    <= RD;
                        end
                    end
                end
                RD: begin
                    if (lat_we && (lat_be != '0)) begin
                        mem_w_en    <= 1'b1;
                        mem_data_in <= merged;
                        resp_rdata  <= merged;
                        state       <= RMW_WR;
                    end else begin
                        resp_rdata <= mem_data_o;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RMW_WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    // A full write enters here straight from IDLE; its response
                    // is raised one cycle later, after the BRAM write has landed.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Self-checking bench for bram_port_ctrl: behavioural negedge BRAM, directed
// vector table, multi-cycle corner sequences and a randomised scoreboard run.
module tb_bram_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        mem_w_en;
    logic        mem_r_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_o = 32'h0;

    bram_port_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_o(mem_data_o)
    );

    always #5 clk = ~clk;

    // Behavioural 256 x 32 BRAM, clocked on the falling edge.
    logic [31:0] bram [256] = '{default: 32'h0};
    always @(negedge clk) begin
        if (mem_w_en) bram[mem_addr] <= mem_data_in;
        if (mem_r_en) mem_data_o <= bram[mem_addr];
    end

    // Enable monitors, sampled mid-cycle.
    int          w_pulses = 0, r_pulses = 0, overlap_cnt = 0, long_cnt = 0;
    logic        prev_w = 1'b0, prev_r = 1'b0;
    logic [31:0] last_w_data = 32'h0;
    always @(negedge clk) begin
        if (mem_w_en && mem_r_en) overlap_cnt <= overlap_cnt + 1;
        if ((mem_w_en && prev_w) || (mem_r_en && prev_r)) long_cnt <= long_cnt + 1;
        if (mem_w_en) begin
            w_pulses    <= w_pulses + 1;
            last_w_data <= mem_data_in;
        end
        if (mem_r_en) r_pulses <= r_pulses + 1;
        prev_w <= mem_w_en;
        prev_r <= mem_r_en;
    end

    int          n_cmp = 0, n_fail = 0, n_txn = 0;
    logic [31:0] sb_q [$];
    logic [31:0] model [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [31:0] model_apply(input logic we, input logic [3:0] be,
                                                input logic [7:0] addr, input logic [31:0] wdata);
        logic [31:0] w;
        w = model[addr];
        if (we && be != 4'h0) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
            model[addr] = w;
        end
        return w;
    endfunction

    task automatic run_req(input logic we, input logic [3:0] be, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input int exp_lat, input int exp_w, input int exp_r);
        int          w0, r0, lat, guard;
        logic [31:0] want;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
        sb_q.push_back(exp_rdata);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            fail_now("req_ready");
            req_valid = 1'b0;
            void'(sb_q.pop_back());
            return;
        end
        w0 = w_pulses; r0 = r_pulses;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        want = sb_q.pop_front();
        if (resp_valid) begin
            chk("rdata", resp_rdata, want);
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
        end else begin
            fail_now("resp_valid");
        end
        chk("w_pulses", w_pulses - w0, exp_w);
        chk("r_pulses", r_pulses - r0, exp_r);
        if (exp_w == 1) chk("mem_data_in", last_w_data, want);
        $display("txn %0d we=%0b be=%h addr=%h wdata=%h rdata=%h lat=%0d",
                 n_txn, we, be, addr, wdata, resp_rdata, lat);
        n_txn++;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_w;
        int          exp_r;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int w0;
        logic        we;
        logic [3:0]  be;
        logic [7:0]  addr;
        logic [31:0] wdata, exp;

        vecs[0] = '{1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 0};
        vecs[1] = '{1'b0, 4'h0, 8'h10, 32'h0,        32'hDEADBEEF, 1, 0, 1};
        vecs[2] = '{1'b1, 4'hF, 8'h20, 32'h11223344, 32'h11223344, 1, 1, 0};
        vecs[3] = '{1'b1, 4'h5, 8'h20, 32'hAABBCCDD, 32'h11BB33DD, 2, 1, 1};
        vecs[4] = '{1'b0, 4'hF, 8'h20, 32'h0,        32'h11BB33DD, 1, 0, 1};
        vecs[5] = '{1'b1, 4'h0, 8'h20, 32'h12345678, 32'h11BB33DD, 1, 0, 1};
        vecs[6] = '{1'b0, 4'h0, 8'h20, 32'h0,        32'h11BB33DD, 1, 0, 1};
        vecs[7] = '{1'b1, 4'hA, 8'hFF, 32'hCAFEF00D, 32'hCA00F000, 2, 1, 1};
        vecs[8] = '{1'b0, 4'h0, 8'hFF, 32'h0,        32'hCA00F000, 1, 0, 1};

        for (int i = 0; i < 256; i++) model[i] = 32'h0;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
        req_addr = 8'h0; req_wdata = 32'h0; resp_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mem_en", {30'h0, mem_w_en, mem_r_en}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 chk("rel_req_ready_low", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("rel_req_ready_high", {31'h0, req_ready}, 32'h1);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            void'(model_apply(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata));
            run_req(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_lat, vecs[i].exp_w, vecs[i].exp_r);
        end

        // Backpressure: read 0xFF, hold resp_ready low for 5 cycles
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0; req_addr = 8'hFF;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!resp_valid && guard < 20) begin @(negedge clk); guard++; end
        if (!resp_valid) fail_now("bp_resp_valid");
        w0 = w_pulses + r_pulses;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
            chk("bp_rdata", resp_rdata, 32'hCA00F000);
            chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
        end
        chk("bp_no_mem_pulse", w_pulses + r_pulses - w0, 32'h0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_req_ready", {31'h0, req_ready}, 32'h1);
        chk("bp_resp_dropped", {31'h0, resp_valid}, 32'h0);
        $display("txn %0d backpressure read addr=ff rdata=%h", n_txn, resp_rdata);
        n_txn++;

        // Reset while a response is pending
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!resp_valid && guard < 20) begin @(negedge clk); guard++; end
        if (!resp_valid) fail_now("rst_mid_resp_valid");
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("mid_rst_rdata", resp_rdata, 32'h0);
        chk("mid_rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("mid_rst_mem", {30'h0, mem_w_en, mem_r_en}, 32'h0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        w0 = w_pulses;
        @(negedge clk);
        chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        repeat (5) @(negedge clk);
        chk("post_rst_no_write", w_pulses - w0, 32'h0);
        $display("txn %0d reset with pending response", n_txn);
        n_txn++;
        run_req(1'b0, 4'h0, 8'h10, 32'h0, model[8'h10], 1, 0, 1);

        // Random back-to-back requests against the model
        for (int n = 0; n < 200; n++) begin
            we    = 1'($urandom_range(0, 1));
            be    = 4'($urandom_range(0, 15));
            addr  = (n % 5 == 0) ? 8'($urandom_range(0, 255)) : 8'(8'h40 + $urandom_range(0, 7));
            wdata = $urandom;
            exp   = model_apply(we, be, addr, wdata);
            run_req(we, be, addr, wdata, exp,
                    (we && be != 4'h0 && be != 4'hF) ? 2 : 1,
                    (we && be != 4'h0) ? 1 : 0,
                    (we && be == 4'hF) ? 0 : 1);
        end

        chk("en_overlap", overlap_cnt, 32'h0);
        chk("en_long_pulse", long_cnt, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
